xlat_arbiter: RTL and testbench
===============================

Name: xlat_arbiter

Overview:
- Shares one fixed-mapping MIPS address translator between the instruction-fetch port (I) and the data-memory port (D) of the CPU.
- Accepts at most one translation per cycle, arbitrating between ports round-robin.
- Registers each port's result in a one-entry response slot with valid/ready handshake.
- Sits between the fetch/memory stages and the cache/bus interface; also flags user-mode kernel-segment address errors.

Parameters:
- ADDR_W, 32, virtual/physical address width; only 32 is supported.
- D_FIRST, 1, on reset the first contended grant goes to D (1) or I (0).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush; discards I-port slot and I request this cycle
- i_req_valid  in  1  I translation request
- i_req_vaddr  in  ADDR_W  I virtual address
- i_req_user  in  1  requester is in user mode
- i_req_ready  out  1  I request accepted this cycle
- i_resp_valid  out  1  I slot full
- i_resp_ready  in  1  I consumer takes result
- i_resp_paddr  out  ADDR_W  translated address
- i_resp_uncached  out  1  kseg1 access
- i_resp_adel  out  1  address error: user access to vaddr[31]=1
- d_req_valid, d_req_vaddr, d_req_user, d_req_ready, d_resp_valid, d_resp_ready, d_resp_paddr, d_resp_uncached, d_resp_adel: same as I-port, for D

Behaviour:
Translation, combinational on the granted request:
- vaddr[31:29]=100 or 101: paddr = {3'b000, vaddr[28:0]}.
- Otherwise: paddr = vaddr.
- uncached = (vaddr[31:29]==3'b101).
- adel = user & vaddr[31]. When adel=1, paddr is still computed but consumers ignore it.

Slots:
- Each port has one result slot with states EMPTY and FULL.
- Eligible(p) = req_valid(p) & (slot EMPTY | (resp_valid(p) & resp_ready(p))). Same-cycle drain plus refill is allowed, giving full throughput.
- FULL to EMPTY on resp_ready with no new accept.
- EMPTY or FULL to FULL on accept.

Arbitration:
- Exactly one grant per cycle.
- Only one port eligible: that port is granted.
- Both eligible: the port that did not win the last contended grant wins.
- last_winner updates only on contended cycles.
- req_ready(p) = grant(p). It is combinational from req_valid, slot state and resp_ready; there is no combinational path from req_vaddr.

Latency:
- Request accepted in cycle N gives resp_valid high from cycle N+1, with fields held stable until resp_ready.
- A port may present a new request on the cycle its response is consumed.

Flush:
- The I slot goes to EMPTY next edge regardless of resp_ready.
- i_req_ready is forced 0 that cycle, so I cannot be granted and D may win uncontended.
- The D slot is unaffected.

Reset (asynchronous, any time, including mid-handshake):
- Both slots EMPTY; all resp_valid=0; paddr, uncached and adel = 0.
- last_winner is set so that the first contended grant goes to D if D_FIRST=1, otherwise I.
- Requests are ignored while reset is high.

Invariants:
- Never both req_ready high.
- resp fields never change while resp_valid=1 and resp_ready=0.

Test Plan:
- Directed: I-only request vaddr=0xBFC00000, user=0 → i_req_ready=1 same cycle; next cycle i_resp_valid=1, paddr=0x1FC00000, uncached=1, adel=0.
- Directed: D-only requests 0x80001234, 0x9000_0010, 0x00400000 → paddr 0x00001234 cached, 0x10000010 cached, 0x00400000 cached; with user=1 on 0x80001234 → adel=1.
- Directed: both request every cycle, both resp_ready=1 → grants alternate D,I,D,I from reset (D_FIRST=1); each port gets one result per 2 cycles.
- Directed: I slot full with i_resp_ready=0 for 3 cycles while both request → D granted every cycle and I not granted; I result stays stable; when i_resp_ready rises, I is accepted the same cycle.
- Directed: flush while I slot full and I requesting, D requesting → next cycle i_resp_valid=0, D granted, D result intact.
- Directed: assert reset asynchronously mid-cycle with both slots full → resp_valid drops immediately; after release the first contended grant goes to D.

Source files
------------

// File: rtl/xlat_arbiter.sv
// xlat_arbiter: shares one fixed-mapping MIPS address translator between the
// instruction-fetch (I) and data-memory (D) ports. Each cycle it accepts at
// most one request, chosen round-robin between contending ports. Each result
// is held in a one-entry response slot per port, with a valid/ready handshake.
module xlat_arbiter #(
    parameter int ADDR_W  = 32,
    parameter bit D_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_vaddr,
    input  logic              i_req_user,
    output logic              i_req_ready,
    output logic              i_resp_valid,
    input  logic              i_resp_ready,
    output logic [ADDR_W-1:0] i_resp_paddr,
    output logic              i_resp_uncached,
    output logic              i_resp_adel,

    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_vaddr,
    input  logic              d_req_user,
    output logic              d_req_ready,
    output logic              d_resp_valid,
    input  logic              d_resp_ready,
    output logic [ADDR_W-1:0] d_resp_paddr,
    output logic              d_resp_uncached,
    output logic              d_resp_adel
);

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_t;
    typedef enum logic {WIN_I, WIN_D} win_t;

    slot_t i_slot, d_slot;
    win_t  last_winner;

    logic              i_elig, d_elig, grant_i, grant_d, contended;
    logic [ADDR_W-1:0] sel_vaddr, x_paddr;
    logic              sel_user, x_uncached, x_adel;

    // Eligibility and round-robin grant. This logic depends only on valid,
    // slot state, resp_ready, flush and reset; it never depends on an address.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        i_elig    = 1'b0;
        d_elig    = 1'b0;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        contended = 1'b0;
        if (!reset) begin
            i_elig = !flush && i_req_valid && (i_slot == SLOT_EMPTY || i_resp_ready);
            d_elig = d_req_valid && (d_slot == SLOT_EMPTY || d_resp_ready);
        end
        contended = i_elig && d_elig;
        grant_d   = d_elig && (!i_elig || last_winner == WIN_I);
        grant_i   = i_elig && !grant_d;
    end

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;

    // Fixed-mapping translation of whichever request was granted.
    // kseg0 and kseg1 (vaddr[31:30] == 2'b10) drop the top three bits.
    always_comb begin
        sel_vaddr  = grant_d ? d_req_vaddr : i_req_vaddr;
        sel_user   = grant_d ? d_req_user  : i_req_user;
        x_paddr    = sel_vaddr;
        if (sel_vaddr[ADDR_W-1 -: 2] == 2'b10)
            x_paddr = {3'b000, sel_vaddr[ADDR_W-4:0]};
        x_uncached = (sel_vaddr[ADDR_W-1 -: 3] == 3'b101);
        x_adel     = sel_user && sel_vaddr[ADDR_W-1];
    end

    // I result slot: a flush empties it unconditionally; otherwise an accept
    // fills it, and a consume with no accept drains it.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            i_slot          <= SLOT_EMPTY;
            i_resp_paddr    <= '0;
            i_resp_uncached <= 1'b0;
            i_resp_adel     <= 1'b0;
        end else if (flush) begin
            i_slot <= SLOT_EMPTY;
        end else if (grant_i) begin
            i_slot          <= SLOT_FULL;
            i_resp_paddr    <= x_paddr;
            i_resp_uncached <= x_uncached;
            i_resp_adel     <= x_adel;
        end else if (i_slot == SLOT_FULL && i_resp_ready) begin
            i_slot <= SLOT_EMPTY;
        end
    end

    // D result slot: same as the I slot, but flush does not affect it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_slot          <= SLOT_EMPTY;
            d_resp_paddr    <= '0;
            d_resp_uncached <= 1'b0;
            d_resp_adel     <= 1'b0;
        end else if (grant_d) begin
            d_slot          <= SLOT_FULL;
            d_resp_paddr    <= x_paddr;
            d_resp_uncached <= x_uncached;
            d_resp_adel     <= x_adel;
        end else if (d_slot == SLOT_FULL && d_resp_ready) begin
            d_slot <= SLOT_EMPTY;
        end
    end

    // Round-robin history. It advances only when both ports contended.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_winner <= D_FIRST ? WIN_I : WIN_D;
        else if (contended)
            last_winner <= grant_d ? WIN_D : WIN_I;
    end

    assign i_resp_valid = (i_slot == SLOT_FULL);
    assign d_resp_valid = (d_slot == SLOT_FULL);

endmodule

// File: tb/tb_xlat_arbiter.sv
// Self-checking bench for xlat_arbiter: a table of single-port translations,
// followed by hand-written sequences for arbitration, stall, flush and reset.
module tb_xlat_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        i_req_valid, i_req_user, i_req_ready, i_resp_valid, i_resp_ready;
    logic        i_resp_uncached, i_resp_adel;
    logic [31:0] i_req_vaddr, i_resp_paddr;
    logic        d_req_valid, d_req_user, d_req_ready, d_resp_valid, d_resp_ready;
    logic        d_resp_uncached, d_resp_adel;
    logic [31:0] d_req_vaddr, d_resp_paddr;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    xlat_arbiter #(.ADDR_W(32), .D_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .i_req_valid(i_req_valid), .i_req_vaddr(i_req_vaddr), .i_req_user(i_req_user),
        .i_req_ready(i_req_ready), .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready),
        .i_resp_paddr(i_resp_paddr), .i_resp_uncached(i_resp_uncached), .i_resp_adel(i_resp_adel),
        .d_req_valid(d_req_valid), .d_req_vaddr(d_req_vaddr), .d_req_user(d_req_user),
        .d_req_ready(d_req_ready), .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
        .d_resp_paddr(d_resp_paddr), .d_resp_uncached(d_resp_uncached), .d_resp_adel(d_resp_adel)
    );

    typedef struct {
        logic        port_d;
        logic [31:0] vaddr;
        logic        user;
        logic [31:0] paddr;
        logic        uncached;
        logic        adel;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] ia, input logic iu, input logic irr,
                         input logic dv, input logic [31:0] da, input logic du, input logic drr,
                         input logic fl);
        i_req_valid = iv; i_req_vaddr = ia; i_req_user = iu; i_resp_ready = irr;
        d_req_valid = dv; d_req_vaddr = da; d_req_user = du; d_resp_ready = drr;
        flush = fl;
    endtask

    task automatic chk_ready(input string name, input logic exp_i, input logic exp_d);
        check({name, " i_req_ready"}, {31'd0, i_req_ready}, {31'd0, exp_i});
        check({name, " d_req_ready"}, {31'd0, d_req_ready}, {31'd0, exp_d});
    endtask

    task automatic chk_i(input string name, input logic v, input logic [31:0] pa,
                         input logic unc, input logic adel);
        check({name, " i_resp_valid"}, {31'd0, i_resp_valid}, {31'd0, v});
        check({name, " i_resp_paddr"}, i_resp_paddr, pa);
        check({name, " i_resp_uncached"}, {31'd0, i_resp_uncached}, {31'd0, unc});
        check({name, " i_resp_adel"}, {31'd0, i_resp_adel}, {31'd0, adel});
    endtask

    task automatic chk_d(input string name, input logic v, input logic [31:0] pa,
                         input logic unc, input logic adel);
        check({name, " d_resp_valid"}, {31'd0, d_resp_valid}, {31'd0, v});
        check({name, " d_resp_paddr"}, d_resp_paddr, pa);
        check({name, " d_resp_uncached"}, {31'd0, d_resp_uncached}, {31'd0, unc});
        check({name, " d_resp_adel"}, {31'd0, d_resp_adel}, {31'd0, adel});
    endtask

    initial begin
        // Single-port translations: port, vaddr, user -> paddr, uncached, adel.
        vecs[0] = '{1'b0, 32'hBFC0_0000, 1'b0, 32'h1FC0_0000, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 32'h8000_1234, 1'b0, 32'h0000_1234, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h9000_0010, 1'b0, 32'h1000_0010, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h0040_0000, 1'b0, 32'h0040_0000, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h8000_1234, 1'b1, 32'h0000_1234, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 32'hA000_0004, 1'b0, 32'h0000_0004, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 32'hC000_0000, 1'b0, 32'hC000_0000, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0};

        // Reset state
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_i("reset", 1'b0, 32'h0, 1'b0, 1'b0);
        chk_d("reset", 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;

        // Both ports request every cycle: the grant alternates D, I, D, I, D
        for (int k = 0; k < 5; k++) begin
            drive(1, 32'hA000_0200, 0, 1, 1, 32'h8000_0100, 0, 1, 0);
            #1;
            chk_ready($sformatf("alt%0d", k), k[0], !k[0]);
            tick();
            if (k[0]) begin
                chk_i($sformatf("alt%0d", k), 1'b1, 32'h0000_0200, 1'b1, 1'b0);
                check($sformatf("alt%0d d_resp_valid", k), {31'd0, d_resp_valid}, 32'd0);
            end else begin
                chk_d($sformatf("alt%0d", k), 1'b1, 32'h0000_0100, 1'b0, 1'b0);
                check($sformatf("alt%0d i_resp_valid", k), {31'd0, i_resp_valid}, 32'd0);
            end
        end
        drive(0, 0, 0, 1, 0, 0, 0, 1, 0);
        tick();
        check("drain i_resp_valid", {31'd0, i_resp_valid}, 32'd0);
        check("drain d_resp_valid", {31'd0, d_resp_valid}, 32'd0);

        // Table-driven single-port translations
        for (int n = 0; n < 9; n++) begin
            if (vecs[n].port_d)
                drive(0, 0, 0, 1, 1, vecs[n].vaddr, vecs[n].user, 1, 0);
            else
                drive(1, vecs[n].vaddr, vecs[n].user, 1, 0, 0, 0, 1, 0);
            #1;
            chk_ready($sformatf("vec%0d", n), !vecs[n].port_d, vecs[n].port_d);
            tick();
            drive(0, 0, 0, 1, 0, 0, 0, 1, 0);
            if (vecs[n].port_d) begin
                chk_d($sformatf("vec%0d", n), 1'b1, vecs[n].paddr, vecs[n].uncached, vecs[n].adel);
                check($sformatf("vec%0d i_resp_valid", n), {31'd0, i_resp_valid}, 32'd0);
            end else begin
                chk_i($sformatf("vec%0d", n), 1'b1, vecs[n].paddr, vecs[n].uncached, vecs[n].adel);
                check($sformatf("vec%0d d_resp_valid", n), {31'd0, d_resp_valid}, 32'd0);
            end
        end
        tick();

        // I slot full and stalled: D is granted every cycle, I's result holds
        drive(1, 32'h8000_0040, 0, 0, 0, 0, 0, 1, 0);
        #1;
        chk_ready("fill_i", 1'b1, 1'b0);
        tick();
        chk_i("fill_i", 1'b1, 32'h0000_0040, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h8000_0080, 0, 0, 1, 32'h0000_1000, 0, 1, 0);
            #1;
            chk_ready($sformatf("stall%0d", k), 1'b0, 1'b1);
            tick();
            chk_i($sformatf("stall%0d", k), 1'b1, 32'h0000_0040, 1'b0, 1'b0);
            chk_d($sformatf("stall%0d", k), 1'b1, 32'h0000_1000, 1'b0, 1'b0);
        end
        // i_resp_ready rises: I is accepted in the same cycle (D won the last contention)
        drive(1, 32'h8000_0080, 0, 1, 1, 32'h0000_1000, 0, 1, 0);
        #1;
        chk_ready("unstall", 1'b1, 1'b0);
        tick();
        chk_i("unstall", 1'b1, 32'h0000_0080, 1'b0, 1'b0);
        check("unstall d_resp_valid", {31'd0, d_resp_valid}, 32'd0);

        // Flush with the I slot full and I requesting: D wins, I slot empties
        drive(1, 32'h8000_0100, 0, 0, 1, 32'hA000_1000, 0, 1, 1);
        #1;
        chk_ready("flush", 1'b0, 1'b1);
        tick();
        check("flush i_resp_valid", {31'd0, i_resp_valid}, 32'd0);
        chk_d("flush", 1'b1, 32'h0000_1000, 1'b1, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("post_flush i_resp_valid", {31'd0, i_resp_valid}, 32'd0);
        chk_d("post_flush", 1'b1, 32'h0000_1000, 1'b1, 1'b0);

        // Fill both slots, making D the last contended winner
        drive(1, 32'h0000_0010, 0, 0, 1, 32'h0000_2000, 0, 1, 0);
        #1;
        chk_ready("pre_rst_a", 1'b0, 1'b1);
        tick();
        drive(1, 32'h0000_0010, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk_ready("pre_rst_b", 1'b1, 1'b0);
        tick();
        chk_i("pre_rst", 1'b1, 32'h0000_0010, 1'b0, 1'b0);
        chk_d("pre_rst", 1'b1, 32'h0000_2000, 1'b0, 1'b0);

        // Asynchronous reset in mid-cycle: outputs clear without a clock edge
        #3;
        reset = 1'b1;
        #1;
        chk_i("async_rst", 1'b0, 32'h0, 1'b0, 1'b0);
        chk_d("async_rst", 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1, 32'hA000_0010, 0, 1, 1, 32'h8000_3000, 1, 1, 0);
        #1;
        chk_ready("in_rst", 1'b0, 1'b0);
        tick();
        check("in_rst i_resp_valid", {31'd0, i_resp_valid}, 32'd0);
        check("in_rst d_resp_valid", {31'd0, d_resp_valid}, 32'd0);
        reset = 1'b0;
        #1;
        chk_ready("post_rst0", 1'b0, 1'b1);
        tick();
        chk_d("post_rst0", 1'b1, 32'h0000_3000, 1'b0, 1'b1);
        check("post_rst0 i_resp_valid", {31'd0, i_resp_valid}, 32'd0);
        chk_ready("post_rst1", 1'b1, 1'b0);
        tick();
        chk_i("post_rst1", 1'b1, 32'h0000_0010, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Invariant: the two request ports are never granted together
    always @(negedge clk) begin
        if (i_req_ready && d_req_ready) begin
            total++;
            $display("FAIL both_ready: got i=%b d=%b expected not both", i_req_ready, d_req_ready);
        end
    end

endmodule
